stage_ra_pipe: RTL

Parametrised Register Address (RA) pipeline stage for the RA->RO boundary. It replaces the plain enable-gated latch with a valid/ready handshake and a 2-entry skid buffer, plus a flush input. It extracts the writeback register address from a parameterised instruction field. It carries PC, instruction, result and flags, and allows back-pressure from RO without losing or duplicating instructions.

---
 rtl/stage_ra_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stage_ra_pipe.sv
// stage_ra_pipe: RA->RO boundary register with valid/ready handshake.
// Holds up to two words (output register plus skid entry) so that RO
// back-pressure never drops or duplicates an instruction. The writeback
// register address is sliced from the instruction as the word is accepted
// and travels with it. SKID=0 collapses the stage to a single register
// whose ready_out looks through to ready_in.
module stage_ra_pipe #(
   parameter int DW     = 24,
   parameter int FW     = 4,
   parameter int RAW    = 4,
   parameter int RA_LSB = 12,
   parameter int SKID   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   output logic            ready_out,
   input  logic            flush,
   input  logic [DW-1:0]   pc_in,
   input  logic [DW-1:0]   instr_in,
   input  logic [DW-1:0]   result_in,
   input  logic [FW-1:0]   flags_in,
   output logic            valid_out,
   input  logic            ready_in,
   output logic [DW-1:0]   pc_out,
   output logic [DW-1:0]   instr_out,
   output logic [DW-1:0]   result_out,
   output logic [FW-1:0]   flags_out,
   output logic [RAW-1:0]  reg_waddr_out,
   output logic [1:0]      occupancy
);

   // state encoding doubles as the held-word count
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef struct packed {
      logic [DW-1:0]  pc;
      logic [DW-1:0]  instr;
      logic [DW-1:0]  result;
      logic [FW-1:0]  flags;
      logic [RAW-1:0] waddr;
   } word_t;

   word_t      in_w;
   word_t      out_q;
   logic [1:0] state;
   logic       accept;
   logic       xfer;

   // pack the incoming word; destination register is captured here so it
   // stays bound to its own instruction through the skid entry
   always_comb begin
      in_w        = '0;
      in_w.pc     = pc_in;
      in_w.instr  = instr_in;
      in_w.result = result_in;
      in_w.flags  = flags_in;
      in_w.waddr  = instr_in[RA_LSB+RAW-1:RA_LSB];
   end

   assign valid_out = (state != ST_EMPTY);
   assign accept    = valid_in & ready_out & ~flush;
   assign xfer      = valid_out & ready_in;
   assign occupancy = state;

   assign pc_out        = out_q.pc;
   assign instr_out     = out_q.instr;
   assign result_out    = out_q.result;
   assign flags_out     = out_q.flags;
   assign reg_waddr_out = out_q.waddr;

   generate
      if (SKID != 0) begin : g_skid
         word_t skid_q;

         // ready depends only on registered state, breaking the ready path
         assign ready_out = (state != ST_TWO);

         // EMPTY/ONE/TWO controller: output register first, skid overflow
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state  <= ST_EMPTY;
               out_q  <= '0;
               skid_q <= '0;
            end else if (flush) begin
               // data left stale; valid drop makes it don't-care
               state <= ST_EMPTY;
            end else begin
               case (state)
                  ST_EMPTY: begin
                     if (accept) begin
                        out_q <= in_w;
                        state <= ST_ONE;
                     end
                  end
                  ST_ONE: begin
                     if (accept && xfer) begin
                        out_q <= in_w;
                     end else if (accept) begin
                        skid_q <= in_w;
                        state  <= ST_TWO;
                     end else if (xfer) begin
                        state <= ST_EMPTY;
                     end
                  end
                  ST_TWO: begin
                     // ready_out is low here, so no accept can coincide
                     if (xfer) begin
                        out_q <= skid_q;
                        state <= ST_ONE;
                     end
                  end
                  default: state <= ST_EMPTY;
               endcase
            end
         end
      end else begin : g_noskid
         // single register: accept whenever the slot is free or draining
         assign ready_out = ~valid_out | ready_in;

         // one-deep holding register
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= ST_EMPTY;
               out_q <= '0;
            end else if (flush) begin
               state <= ST_EMPTY;
            end else if (accept) begin
               out_q <= in_w;
               state <= ST_ONE;
            end else if (xfer) begin
               state <= ST_EMPTY;
            end
         end
      end
   endgenerate

endmodule
